// File: rtl/pipe_pkg.sv
// Shared constants, FSM states and instruction field helpers for the pipeline sequencer.
package pipe_pkg;

  localparam logic [31:0] NOP = 32'hE1A00000;

  localparam logic [1:0] SEL_PC_RESET  = 2'b00;
  localparam logic [1:0] SEL_PC_INC    = 2'b01;
  localparam logic [1:0] SEL_PC_BRANCH = 2'b10;

  typedef enum logic {
    STARTUP = 1'b0,
    RUN     = 1'b1
  } state_t;

  // Single data transfer with the load bit set, excluding the unconditional space.
  function automatic logic is_load(input logic [31:0] instr);
    return (instr[31:28] != 4'b1111) && (instr[27:26] == 2'b01) && instr[20];
  endfunction

  function automatic logic [3:0] rd_of(input logic [31:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [3:0] rn_of(input logic [31:0] instr);
    return instr[19:16];
  endfunction

  function automatic logic [3:0] rm_of(input logic [31:0] instr);
    return instr[3:0];
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: instruction word plus valid bit with advance/hold/bubble control.
module pipe_stage_reg
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        bubble,
  input  logic [31:0] next_instr,
  input  logic        next_valid,
  output logic [31:0] instr,
  output logic        valid
);

  // Bubble overrides advance; neither asserted means hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (advance) begin
      instr <= next_instr;
      valid <= next_valid;
    end
  end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: stage registers, load-use stall, branch squash and PC start-up control.
module pipe_sequencer
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned BRANCH_STAGE   = 1,
  parameter int unsigned LOAD_SHADOW    = 2,
  parameter int unsigned STARTUP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              instr_in,
  input  logic                     instr_valid_in,
  input  logic                     stall_req,
  input  logic                     branch_taken,
  output logic [NUM_STAGES*32-1:0] stage_instr,
  output logic [NUM_STAGES-1:0]    stage_valid,
  output logic [1:0]               sel_pc,
  output logic                     load_pc,
  output logic                     fetch_accept,
  output logic                     stall_out,
  output logic                     squash_out
);

  localparam int unsigned CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run, hazard, squash, stall;

  logic [31:0]           instr_q [NUM_STAGES];
  logic [31:0]           instr_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q, valid_d, advance, bubble, hit;

  assign run    = (state_q == RUN);
  assign hazard = valid_q[0] & (|hit);
  assign squash = run & branch_taken & valid_q[BRANCH_STAGE];
  assign stall  = run & ~squash & (stall_req | hazard);

  assign stall_out   = stall;
  assign squash_out  = squash;
  assign stage_valid = valid_q;

  // Per-stage control, data path and load-use comparison against stage 0.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign instr_d[k] = instr_valid_in ? instr_in : NOP;
      assign valid_d[k] = instr_valid_in;
      assign advance[k] = run & ~stall;
      assign bubble[k]  = squash;
    end else begin : g_tail
      assign instr_d[k] = instr_q[k-1];
      assign valid_d[k] = valid_q[k-1];
      assign advance[k] = run;
      assign bubble[k]  = (squash & (k <= BRANCH_STAGE)) | (stall & (k == 1));
    end

    if ((k >= 1) && (k <= LOAD_SHADOW)) begin : g_hit
      assign hit[k] = valid_q[k] & is_load(instr_q[k]) &
                      ((rd_of(instr_q[k]) == rn_of(instr_q[0])) |
                       (rd_of(instr_q[k]) == rm_of(instr_q[0])));
    end else begin : g_nohit
      assign hit[k] = 1'b0;
    end

    pipe_stage_reg u_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .advance    (advance[k]),
      .bubble     (bubble[k]),
      .next_instr (instr_d[k]),
      .next_valid (valid_d[k]),
      .instr      (instr_q[k]),
      .valid      (valid_q[k])
    );

    assign stage_instr[32*k +: 32] = instr_q[k];
  end

  // FSM state and start-up counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STARTUP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and PC/fetch controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_pc       = SEL_PC_RESET;
    load_pc      = 1'b0;
    fetch_accept = 1'b0;
    case (state_q)
      STARTUP: begin
        load_pc = 1'b1;
        if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (squash) begin
          sel_pc  = SEL_PC_BRANCH;
          load_pc = 1'b1;
        end else if (stall) begin
          sel_pc  = SEL_PC_INC;
          load_pc = 1'b0;
        end else begin
          sel_pc       = SEL_PC_INC;
          load_pc      = 1'b1;
          fetch_accept = instr_valid_in;
        end
      end
      default: state_d = STARTUP;
    endcase
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: directed scenarios plus random traffic against a cycle model.
module tb_pipe_sequencer;

  localparam int N  = 4;
  localparam int B  = 1;
  localparam int LS = 2;
  localparam int SC = 3;
  localparam logic [31:0] NOPW = 32'hE1A00000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     instr_in = 32'h0;
  logic            instr_valid_in = 1'b0;
  logic            stall_req = 1'b0;
  logic            branch_taken = 1'b0;
  logic [N*32-1:0] stage_instr;
  logic [N-1:0]    stage_valid;
  logic [1:0]      sel_pc;
  logic            load_pc, fetch_accept, stall_out, squash_out;

  pipe_sequencer #(
    .NUM_STAGES(N), .BRANCH_STAGE(B), .LOAD_SHADOW(LS), .STARTUP_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid_in(instr_valid_in),
    .stall_req(stall_req), .branch_taken(branch_taken), .stage_instr(stage_instr),
    .stage_valid(stage_valid), .sel_pc(sel_pc), .load_pc(load_pc),
    .fetch_accept(fetch_accept), .stall_out(stall_out), .squash_out(squash_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pipeline contents, run flag and remaining start-up cycles.
  logic [31:0] m_instr [N];
  logic        m_valid [N];
  bit          m_run;
  int          m_left;

  logic [1:0] obs_sel;
  logic       obs_load, obs_fa, obs_stall, obs_squash;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit ld(input logic [31:0] x);
    return ((x >> 28) != 15) && (((x >> 26) & 3) == 1) && (((x >> 20) & 1) == 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_instr[k] = NOPW;
      m_valid[k] = 1'b0;
    end
    m_run  = 1'b0;
    m_left = SC;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic [31:0] ins, input bit iv, input bit sr, input bit bt);
    bit hz, sq, st, exp_load;
    logic [31:0] ni [N];
    logic        nv [N];
    @(negedge clk);
    instr_in = ins; instr_valid_in = iv; stall_req = sr; branch_taken = bt;
    #1;
    hz = 1'b0;
    for (int k = 1; k <= LS; k++)
      if (m_valid[k] && ld(m_instr[k]) &&
          ((((m_instr[k] >> 12) & 15) == ((m_instr[0] >> 16) & 15)) ||
           (((m_instr[k] >> 12) & 15) == (m_instr[0] & 15))))
        hz = 1'b1;
    hz = hz && m_valid[0];
    sq = m_run && bt && m_valid[B];
    st = m_run && !sq && (sr || hz);
    exp_load = !m_run || sq || !st;
    obs_sel = sel_pc; obs_load = load_pc; obs_fa = fetch_accept;
    obs_stall = stall_out; obs_squash = squash_out;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("stage_instr[%0d]", k), 64'(stage_instr[32*k +: 32]), 64'(m_instr[k]));
      chk($sformatf("stage_valid[%0d]", k), 64'(stage_valid[k]), 64'(m_valid[k]));
    end
    chk("stall_out", 64'(stall_out), 64'(st));
    chk("squash_out", 64'(squash_out), 64'(sq));
    chk("load_pc", 64'(load_pc), 64'(exp_load));
    if (exp_load)
      chk("sel_pc", 64'(sel_pc), !m_run ? 64'd0 : (sq ? 64'd2 : 64'd1));
    chk("fetch_accept", 64'(fetch_accept), 64'(m_run && !sq && !st && iv));
    // Next pipeline contents.
    for (int k = 0; k < N; k++) begin
      ni[k] = m_instr[k];
      nv[k] = m_valid[k];
    end
    if (m_run) begin
      for (int k = N - 1; k >= 1; k--) begin
        ni[k] = m_instr[k-1];
        nv[k] = m_valid[k-1];
      end
      if (sq) begin
        for (int k = 0; k <= B; k++) begin
          ni[k] = NOPW;
          nv[k] = 1'b0;
        end
      end else if (st) begin
        ni[0] = m_instr[0]; nv[0] = m_valid[0];
        ni[1] = NOPW;       nv[1] = 1'b0;
      end else begin
        ni[0] = iv ? ins : NOPW;
        nv[0] = iv;
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_instr[k] = ni[k];
        m_valid[k] = nv[k];
      end
      if (!m_run) begin
        m_left--;
        if (m_left == 0) m_run = 1'b1;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) step(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] rd, rn, rm;
    rd = 4'($urandom_range(0, 3));
    rn = 4'($urandom_range(0, 3));
    rm = 4'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       return {4'hE, 8'h59, rn, rd, 12'h000};
      1:       return {4'hF, 8'h59, rn, rd, 12'h000};
      2:       return {4'hE, 8'h08, rn, rd, 8'h00, rm};
      default: return $urandom();
    endcase
  endfunction

  localparam logic [31:0] I1  = 32'hE0811002;
  localparam logic [31:0] I2  = 32'hE0822003;
  localparam logic [31:0] I3  = 32'hE0833004;
  localparam logic [31:0] LDR = 32'hE5921000;
  localparam logic [31:0] ADD = 32'hE0813004;
  localparam logic [31:0] XI  = 32'hE0855006;
  localparam logic [31:0] BR  = 32'hE0844005;
  localparam logic [31:0] YI  = 32'hE0866007;

  initial begin
    int stalls;
    model_reset();
    step(32'h0, 1'b0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Start-up: reset vector held for SC cycles, nothing enters the pipe.
    for (int i = 0; i < SC; i++) begin
      step(I1, 1'b1, 1'b0, 1'b0);
      chk("startup_sel", 64'(obs_sel), 64'd0);
      chk("startup_load", 64'(obs_load), 64'd1);
      chk("startup_valid", 64'(stage_valid), 64'd0);
      chk("startup_instr0", 64'(stage_instr[31:0]), 64'hE1A00000);
    end

    // Straight-line code.
    step(I1, 1'b1, 1'b0, 1'b0);
    chk("first_run_sel", 64'(obs_sel), 64'd1);
    chk("line_valid1", 64'(stage_valid), 64'b0001);
    step(I2, 1'b1, 1'b0, 1'b0);
    chk("line_valid2", 64'(stage_valid), 64'b0011);
    step(I3, 1'b1, 1'b0, 1'b0);
    chk("line_valid3", 64'(stage_valid), 64'b0111);
    chk("line_s2", 64'(stage_instr[95:64]), 64'(I1));
    chk("line_s0", 64'(stage_instr[31:0]), 64'(I3));
    drain();

    // Load-use: two stall cycles with bubbles in stage 1.
    step(LDR, 1'b1, 1'b0, 1'b0);
    step(ADD, 1'b1, 1'b0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      step(XI, 1'b1, 1'b0, 1'b0);
      if (i < 2) begin
        chk("lu_stall", 64'(obs_stall), 64'd1);
        chk("lu_load_pc", 64'(obs_load), 64'd0);
        chk("lu_fetch", 64'(obs_fa), 64'd0);
        chk("lu_bubble", 64'(stage_valid[1]), 64'd0);
      end
      stalls += int'(obs_stall);
    end
    chk("lu_stall_count", 64'(stalls), 64'd2);
    chk("lu_add_s1", 64'(stage_instr[63:32]), 64'(ADD));
    drain();

    // Branch squash.
    step(BR, 1'b1, 1'b0, 1'b0);
    step(XI, 1'b1, 1'b0, 1'b0);
    step(YI, 1'b1, 1'b0, 1'b1);
    chk("sq_flag", 64'(obs_squash), 64'd1);
    chk("sq_sel", 64'(obs_sel), 64'd2);
    chk("sq_load", 64'(obs_load), 64'd1);
    chk("sq_fetch", 64'(obs_fa), 64'd0);
    chk("sq_valid_lo", 64'(stage_valid[1:0]), 64'd0);
    chk("sq_branch_s2", 64'(stage_instr[95:64]), 64'(BR));

    // Branch taken with an invalid branch stage is ignored.
    step(XI, 1'b1, 1'b0, 1'b1);
    chk("nosq_flag", 64'(obs_squash), 64'd0);
    chk("nosq_fetch", 64'(obs_fa), 64'd1);

    // Stall request and branch together: squash wins.
    step(I1, 1'b1, 1'b0, 1'b0);
    step(I2, 1'b1, 1'b1, 1'b1);
    chk("both_squash", 64'(obs_squash), 64'd1);
    chk("both_stall", 64'(obs_stall), 64'd0);
    chk("both_valid_lo", 64'(stage_valid[1:0]), 64'd0);
    drain();

    // Reset asserted in the middle of a load-use stall.
    step(LDR, 1'b1, 1'b0, 1'b0);
    step(ADD, 1'b1, 1'b0, 1'b0);
    step(XI, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(stage_valid), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    chk("rst_load", 64'(load_pc), 64'd1);
    chk("rst_sel", 64'(sel_pc), 64'd0);
    model_reset();
    step(XI, 1'b1, 1'b0, 1'b0);
    step(XI, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst_n = 1'b0;
        model_reset();
        step(32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end
      step(rand_instr(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
